// File: rtl/banco_registradores_param.sv
// Parametrised nRisc register file: two combinational read ports, one write port,
// an observation tap and a per-register pending-write scoreboard.
module banco_registradores_param #(
    parameter int unsigned LARGURA = 8,
    parameter int unsigned ENDW    = 4,
    parameter int unsigned REG_OBS = 7,
    parameter bit          ZERO_R0 = 1'b0,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [ENDW-1:0]    RegLido1,
    input  logic [ENDW-1:0]    RegLido2,
    input  logic [ENDW-1:0]    RegEscrito,
    input  logic [LARGURA-1:0] DadoEscrito,
    input  logic               EscReg,
    input  logic               Reserva,
    input  logic [ENDW-1:0]    RegReserva,
    output logic [LARGURA-1:0] DadoLido1,
    output logic [LARGURA-1:0] DadoLido2,
    output logic [LARGURA-1:0] DadoObs,
    output logic               Ocupado1,
    output logic               Ocupado2
);

    localparam int unsigned     NREG    = 2 ** ENDW;
    localparam logic [ENDW-1:0] OBS_IDX = ENDW'(REG_OBS);

    logic [LARGURA-1:0] regs_q [NREG];
    logic [LARGURA-1:0] regs_d [NREG];
    logic [NREG-1:0]    busy_q;
    logic [NREG-1:0]    busy_d;

    logic               wr_en;
    logic               rsv_en;

    logic [ENDW-1:0]    rd_addr [2];
    logic [LARGURA-1:0] rd_data [2];
    logic [1:0]         rd_busy;

    assign wr_en  = EscReg  && !(ZERO_R0 && (RegEscrito == '0));
    assign rsv_en = Reserva && !(ZERO_R0 && (RegReserva == '0));

    // Reservation is applied after the write so a colliding reserve keeps the bit set.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[RegEscrito] = DadoEscrito;
            busy_d[RegEscrito] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[RegReserva] = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign rd_addr[0] = RegLido1;
    assign rd_addr[1] = RegLido2;

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
            if (ZERO_R0 && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end else begin
                if (BYPASS && EscReg && (RegEscrito == rd_addr[p])) begin
                    rd_data[p] = DadoEscrito;
                end
                // A same-cycle reservation marks a newer producer, overriding the bypass.
                if (Reserva && (RegReserva == rd_addr[p])) begin
                    rd_busy[p] = 1'b1;
                end else if (BYPASS && EscReg && (RegEscrito == rd_addr[p])) begin
                    rd_busy[p] = 1'b0;
                end
            end
        end
    end

    assign DadoLido1 = rd_data[0];
    assign DadoLido2 = rd_data[1];
    assign Ocupado1  = rd_busy[0];
    assign Ocupado2  = rd_busy[1];
    assign DadoObs   = regs_q[OBS_IDX];

endmodule
